uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
// - UART transmitter: serialises one 5..8-bit character per request onto tx; optional parity; 1 or 2 stop bits.
// - Transmit end of the UART_APB link; the APB register block drives config/data, tx drives the peripheral pin.
// - Frame and parity convention are identical to uart_rx, so a uart_tx -> uart_rx loopback is error-free.
// PARAMETERS
// - BAUD_DIV  16  clocks per serial bit; legal range 2..255; baud counter width = $clog2(BAUD_DIV)
// PORTS
// - clk           in   1  system clock; all logic on rising edge
// - reset         in   1  synchronous, active-high reset
// - data_bit_num  in   2  00=5, 01=6, 10=7, 11=8 data bits
// - stop_bit_num  in   1  0=1 stop bit, 1=2 stop bits
// - parity_en     in   1  1=append parity bit after data
// - parity_type   in   1  0=odd, 1=even (over transmitted data bits + parity bit)
// - tx_data       in   8  character; LSB sent first; bits above width ignored
// - tx_start      in   1  request; accepted only on a cycle where tx_ready=1
// - tx_ready      out  1  1 = idle and able to accept (reset 0)
// - tx_done       out  1  1-cycle pulse at end of last stop bit (reset 0)
// - tx            out  1  serial line, registered, idle high (reset 1)
// - cts_n         in   1  clear-to-send from peripheral, active low
// BEHAVIOUR
// - Reset: state=IDLE, tx=1, tx_ready=0, tx_done=0, counters 0; tx_ready=1 from first cycle after reset drops.
// - Accept = tx_start & tx_ready. On accept, latch tx_data, data_bit_num, stop_bit_num, parity_en,
//   parity_type; input changes mid-frame have no effect on the current frame.
// - tx_start while tx_ready=0 is ignored (no queueing, no error).
// - FSM: IDLE -> START -> DATA -> [PARITY if parity_en] -> STOP -> IDLE.
//   IDLE: tx=1; on accept -> START. START: tx=0 for BAUD_DIV clocks.
//   DATA: tx=shift[0] each bit, shift right; after N bits (N from latched data_bit_num) -> PARITY or STOP.
//   PARITY: tx = even ? ^data[N-1:0] : ~^data[N-1:0]; one bit time.
//   STOP: tx=1 for 1 or 2 bit times -> IDLE.
// - Every bit lasts exactly BAUD_DIV clocks; baud counter cleared on accept and at each bit boundary.
// - Latency: tx falls on the clock edge after accept; frame = BAUD_DIV*(1+N+P+S) clocks.
// - Final clock of last stop bit: FSM -> IDLE; tx_done and tx_ready both rise on that edge; tx_done is
//   high exactly one cycle. A tx_start in that first ready cycle is accepted; tx stays 1 no extra bit time
//   beyond the stop bit(s), i.e. back-to-back frames have zero idle gap.
// - tx_ready=0 in every state but IDLE; tx_done never asserts for an aborted frame.
// - Reset mid-frame: frame aborted, tx=1 on next edge, no tx_done; latched data discarded.
// CONFIGURATION
// - Macro UART_TX_CTS_EN defined: tx_ready = (state==IDLE) & ~cts_n; start of frame waits for cts_n=0.
//   cts_n rising mid-frame does not abort; the current frame completes incl. stop bits.
// - Macro undefined: cts_n ignored (port kept, unused); tx_ready = (state==IDLE).
// TESTING (BAUD_DIV=16 unless noted)
// - 8N1, tx_data=0xA5, one-cycle tx_start -> tx = 0,1,0,1,0,0,1,0,1,1 each 16 clks; tx_done at clk 160
//   after accept; tx_ready low for those 160 clks.
// - 5O2 (00,1,en=1,type=0), tx_data=0xFF -> start,1,1,1,1,1,parity=0,1,1; 144 clks; upper bits not sent.
// - 7E1, tx_data=0x07 -> data 1,1,1,0,0,0,0 then parity=1, stop=1; uart_rx loopback reports parity_error=0.
// - Back-to-back: tx_start held high with 0x55 then 0x0F -> second start bit begins on edge after tx_done,
//   no idle high bit between frames; tx_data changed mid-frame does not alter frame 1.
// - Reset asserted at clk 50 of an 8N1 frame -> tx=1 next edge, tx_done never pulses, tx_ready=1 after release.
// - UART_TX_CTS_EN, cts_n=1, tx_start held -> tx stays 1, tx_ready=0; cts_n->0 -> frame starts next edge;
//   cts_n->1 mid-frame -> frame completes; without macro, same stimulus -> frame starts immediately.

Source files
------------

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - request/config/serial bundle between the register block and uart_tx
interface uart_tx_if;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic       tx_done;
    logic       tx;
    logic       cts_n;

    modport master (
        output data_bit_num, stop_bit_num, parity_en, parity_type, tx_data, tx_start, cts_n,
        input  tx_ready, tx_done, tx
    );

    modport slave (
        input  data_bit_num, stop_bit_num, parity_en, parity_type, tx_data, tx_start, cts_n,
        output tx_ready, tx_done, tx
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 5..8 data bits, optional parity, 1/2 stop bits
// Optional flow control: define UART_TX_CTS_EN to gate frame start on cts_n.
module uart_tx #(
    parameter int BAUD_DIV = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    last_bit_q, last_bit_d;
    logic          stop2_q, stop2_d;
    logic          par_en_q, par_en_d;
    logic          par_bit_q, par_bit_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    logic [7:0] mask;
    logic       data_xor;
    logic       accept;
    logic       bit_end;

`ifdef UART_TX_CTS_EN
    assign bus.tx_ready = ready_q & ~bus.cts_n;
`else
    logic cts_n_unused;
    assign cts_n_unused = bus.cts_n;
    assign bus.tx_ready = ready_q;
`endif

    assign bus.tx      = tx_q;
    assign bus.tx_done = done_q;
    assign accept      = bus.tx_start & bus.tx_ready;
    assign bit_end     = (baud_q == BAUD_LAST);

    always_comb begin
        case (bus.data_bit_num)
            2'b00:   mask = 8'h1F;
            2'b01:   mask = 8'h3F;
            2'b10:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
    end

    assign data_xor = ^(bus.tx_data & mask);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + CW'(1);
        shift_d    = shift_q;
        bit_d      = bit_q;
        last_bit_d = last_bit_q;
        stop2_d    = stop2_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                baud_d  = '0;
                if (accept) begin
                    // Snapshot everything so mid-frame input changes cannot leak in.
                    state_d    = S_START;
                    tx_d       = 1'b0;
                    ready_d    = 1'b0;
                    shift_d    = bus.tx_data;
                    bit_d      = '0;
                    last_bit_d = {1'b1, bus.data_bit_num};
                    stop2_d    = bus.stop_bit_num;
                    par_en_d   = bus.parity_en;
                    par_bit_d  = bus.parity_type ? data_xor : ~data_xor;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == last_bit_q) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    if (stop2_q && (bit_q == 3'd0)) begin
                        bit_d = 3'd1;
                    end else begin
                        // Ready rises with done so a held request starts the next frame at once.
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                baud_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            shift_q    <= '0;
            bit_q      <= '0;
            last_bit_q <= '0;
            stop2_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            last_bit_q <= last_bit_d;
            stop2_q    <= stop2_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end
endmodule
